// File: rtl/mem_lsu_pkg.sv
// Shared opcodes, access-size codes and FSM encoding for the memory-stage LSU.
package mem_lsu_pkg;

    localparam int XLEN = 32;
    localparam int ADDR_LSB = 2;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } lsu_state_e;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        unique case (1'b1)
            (f3 == F3_B), (f3 == F3_H), (f3 == F3_W): ok = 1'b1;
            (f3 == F3_BU), (f3 == F3_HU):             ok = !is_store;
            default:                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) ||
               ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus port: req/gnt request phase, rvalid response phase.
interface mem_lsu_if;
    import mem_lsu_pkg::*;

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;
    logic            err;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/enables out, shifted and extended load data in.
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_val
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        unique case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {offset[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        shifted  = rdata >> {offset, 3'b000};
        load_val = shifted;
        unique case (funct3)
            F3_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_val = {24'b0, shifted[7:0]};
            F3_HU:   load_val = {16'b0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: one bus transaction per access, stalls until done.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic            stall_o,
    output logic [XLEN-1:0] load_out_o,
    output logic            exc_o,
    mem_lsu_if.master       dbus
);

    lsu_state_e      state;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic            is_ld;
    logic            is_st;
    logic            mem_op;
    logic            bad;
    logic [2:0]      sel_f3;
    logic [1:0]      sel_off;
    logic [3:0]      be_al;
    logic [XLEN-1:0] wdata_al;
    logic [XLEN-1:0] load_val;

    assign is_ld  = (opcode_i == OPC_LOAD);
    assign is_st  = (opcode_i == OPC_STORE);
    assign mem_op = valid_i && (is_ld || is_st);
    assign bad    = !f3_legal(is_st, funct3_i) ||
                    misaligned(funct3_i, alu_out_i[1:0]);

    // Stores align from live inputs at accept; loads extend from the latched request.
    assign sel_f3  = (state == S_IDLE) ? funct3_i : f3_q;
    assign sel_off = (state == S_IDLE) ? alu_out_i[1:0] : off_q;

    assign stall_o = ((state == S_IDLE) && mem_op) ||
                     (state == S_REQ) || (state == S_WAIT);

    lsu_align u_align (
        .funct3     (sel_f3),
        .offset     (sel_off),
        .store_data (store_data_i),
        .rdata      (dbus.rdata),
        .be         (be_al),
        .wdata      (wdata_al),
        .load_val   (load_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            load_out_o <= '0;
            exc_o      <= 1'b0;
            dbus.req   <= 1'b0;
            dbus.we    <= 1'b0;
            dbus.addr  <= '0;
            dbus.be    <= 4'b0000;
            dbus.wdata <= '0;
        end else begin
            exc_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (mem_op && bad) begin
                        state <= S_DONE;
                        exc_o <= 1'b1;
                    end else if (mem_op) begin
                        state      <= S_REQ;
                        f3_q       <= funct3_i;
                        off_q      <= alu_out_i[1:0];
                        dbus.req   <= 1'b1;
                        dbus.we    <= is_st;
                        dbus.addr  <= {alu_out_i[XLEN-1:ADDR_LSB], 2'b00};
                        dbus.be    <= be_al;
                        dbus.wdata <= wdata_al;
                    end
                end
                S_REQ: begin
                    if (dbus.gnt) begin
                        dbus.req <= 1'b0;
                        state    <= dbus.we ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dbus.rvalid) begin
                        state <= S_DONE;
                        if (dbus.err) exc_o <= 1'b1;
                        else load_out_o <= load_val;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
